// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, canonical NOP and the fetch FSM encoding.
// IFETCH_ALIGN_CHECK_EN adds the FAULT halt state to the fetch FSM.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IF_IDLE  = 3'd0,
        IF_REQ   = 3'd1,
        IF_WAIT  = 3'd2,
        IF_HOLD  = 3'd3
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        IF_FAULT = 3'd4
`endif
    } ifetch_state_e;
endpackage

// File: rtl/ifetch_pc_reg.sv
// Architectural fetch PC: redirect load (low two bits masked) beats sequential +4 increment.
module ifetch_pc_reg
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_pc,
    input  logic            inc_en,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc & ~XLEN'(3);
        end else if (inc_en) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/ifetch_unit.sv
// RV32I fetch stage: single-outstanding imem requests, registered instruction to decode.
// IFETCH_ALIGN_CHECK_EN enables the align_fault port and the FAULT halt on misaligned redirects.
module ifetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [ILEN-1:0] NOP_INSTR    = RV32I_NOP
) (
    input  logic            clk,
    input  logic            rst,
    // valid/ready: a transfer happens on a rising edge where both are high; a
    // producer holds valid and its payload stable until that edge.
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic            align_fault,
`endif
    output ifetch_state_e   dbg_state
);
    ifetch_state_e   state_q, state_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            drop_q, drop_d;
    logic            pc_load, pc_inc, pend_after;
    logic [XLEN-1:0] fetch_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic            align_fault_q, align_fault_d;
`endif

    ifetch_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .load_pc (redirect_pc),
        .inc_en  (pc_inc),
        .pc      (fetch_pc)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        drop_d        = drop_q;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        // A request is still owed a response after this edge.
        pend_after    = (state_q == IF_REQ && imem_req_ready) ||
                        (state_q == IF_WAIT && !imem_resp_valid);
`ifdef IFETCH_ALIGN_CHECK_EN
        align_fault_d = align_fault_q;
        pend_after    = pend_after || (state_q == IF_FAULT && drop_q && !imem_resp_valid);
`endif

        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                if (imem_req_ready) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IF_REQ;
                    end else begin
                        instr_d       = imem_resp_data;
                        instr_pc_d    = fetch_pc;
                        instr_valid_d = 1'b1;
                        pc_inc        = 1'b1;
                        state_d       = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = IF_REQ;
                end
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            IF_FAULT: begin
                if (imem_resp_valid) drop_d = 1'b0;
            end
`endif
            default: state_d = IF_IDLE;
        endcase

        // Redirect wins over everything; an in-flight request becomes a stale drop.
        if (redirect_valid) begin
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            pc_inc        = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                align_fault_d = 1'b1;
                drop_d        = pend_after;
                state_d       = IF_FAULT;
            end else begin
                align_fault_d = 1'b0;
`endif
                pc_load = 1'b1;
                drop_d  = pend_after;
                state_d = pend_after ? IF_WAIT : IF_REQ;
`ifdef IFETCH_ALIGN_CHECK_EN
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IF_IDLE;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            drop_q        <= drop_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= align_fault_d;
        end
    end

    assign align_fault = align_fault_q;
`endif

    assign imem_req_valid = (state_q == IF_REQ);
    assign imem_addr      = fetch_pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + XLEN'(4);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory/decode drivers, a PC-stream model with an expected queue, literal pins.
// Compile with IFETCH_ALIGN_CHECK_EN to exercise the align_fault path.
module tb_ifetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    ifetch_state_e dbg_state;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    ifetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
        .align_fault     (align_fault),
`endif
        .dbg_state       (dbg_state)
    );

    // ---------------- clock/reset ----------------
    always #5 clk = ~clk;

    // ---------------- knobs and shared state (each written by one process) ----------------
    int mem_ready_pct = 100, mem_lat_min = 1, mem_lat_max = 1, dec_mode = 1;
    bit spurious_en = 1'b0;
    bit mem_pending = 1'b0;
    int mem_cnt = 0;
    logic [31:0] mem_addr_l = '0;
    bit thru_win = 1'b0, done = 1'b0, fin_done = 1'b0;
    int timeouts = 0;
    logic [1:0]  lit_kind [256];
    logic [31:0] lit_v1 [256];
    logic [31:0] lit_v2 [256];
    int lit_wr = 0, lit_rd = 0;
    int n_cmp = 0, n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // ---------------- memory driver ----------------
    initial begin
        bit hs;
        logic [31:0] hs_addr;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            hs_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_req_ready = ($urandom_range(99, 0) < mem_ready_pct);
            if (rst) begin
                mem_pending = 1'b0;
            end else begin
                if (hs) begin
                    mem_pending = 1'b1;
                    mem_addr_l = hs_addr;
                    mem_cnt = $urandom_range(mem_lat_max, mem_lat_min);
                end
                if (mem_pending) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data = mem_word(mem_addr_l);
                        mem_pending = 1'b0;
                    end
                end else if (spurious_en && $urandom_range(7, 0) == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = $urandom;
                end
            end
        end
    end

    // ---------------- decode driver ----------------
    initial begin
        instr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (dec_mode)
                0:       instr_ready = $urandom_range(1, 0) == 1;
                1:       instr_ready = 1'b1;
                default: instr_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] exp_pc = 32'h0;
        bit fault_exp = 1'b0, held_prev = 1'b0, new_pres;
        int thru_cyc = 0, thru_cnt = 0, wd = 0, to_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
                chk("rst_instr_valid", 32'(instr_valid), 32'd0);
                chk("rst_instr", instr, NOP);
                chk("rst_instr_pc", instr_pc, 32'h0);
                chk("rst_pc_plus4", instr_pc_plus4, 32'h4);
`ifdef IFETCH_ALIGN_CHECK_EN
                chk("rst_align_fault", 32'(align_fault), 32'd0);
`endif
                exp_pc = 32'h0;
                fault_exp = 1'b0;
                held_prev = 1'b0;
                wd = 0;
            end else begin
                new_pres = instr_valid && !held_prev;
                if (imem_req_valid && instr_valid) chk("req_while_holding", 32'd1, 32'd0);
                if (imem_req_valid) begin
                    chk("req_addr", imem_addr, exp_pc);
                    if (imem_req_ready && mem_pending) chk("single_outstanding", 32'd2, 32'd1);
                end
                if (instr_valid) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr_data", instr, mem_word(exp_pc));
                    chk("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
                end else begin
                    chk("instr_idle_nop", instr, NOP);
                end
`ifdef IFETCH_ALIGN_CHECK_EN
                chk("align_fault", 32'(align_fault), 32'(fault_exp));
                if (fault_exp) chk("fault_no_req", 32'(imem_req_valid), 32'd0);
`endif
                if (lit_rd != lit_wr) begin
                    case (lit_kind[lit_rd[7:0]])
                        2'd0: if (imem_req_valid) begin
                            chk("lit_addr", imem_addr, lit_v1[lit_rd[7:0]]);
                            lit_rd++;
                        end
                        2'd1: if (new_pres) begin
                            chk("lit_pc", instr_pc, lit_v1[lit_rd[7:0]]);
                            chk("lit_pc_plus4", instr_pc_plus4, lit_v2[lit_rd[7:0]]);
                            lit_rd++;
                        end
                        default: begin
`ifdef IFETCH_ALIGN_CHECK_EN
                            chk("lit_align_fault", 32'(align_fault), lit_v1[lit_rd[7:0]]);
                            chk("lit_fault_req", 32'(imem_req_valid), lit_v2[lit_rd[7:0]]);
`endif
                            lit_rd++;
                        end
                    endcase
                end
                if (thru_win) begin
                    thru_cyc++;
                    if (instr_valid) thru_cnt++;
                    if (thru_cyc == 30) chk("throughput_1_in_3", 32'(thru_cnt), 32'd10);
                end else begin
                    thru_cyc = 0;
                    thru_cnt = 0;
                end
                if (!instr_valid && !fault_exp) wd++; else wd = 0;
                if (wd == 150) begin
                    chk("watchdog_no_delivery", 32'(dbg_state), 32'hFFFF_FFFF);
                    wd = 0;
                end
                // Advance the expected PC stream across the coming edge.
                if (redirect_valid) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_exp = 1'b1;
                    end else begin
                        fault_exp = 1'b0;
                        exp_pc = redirect_pc & ~32'd3;
                    end
`else
                    exp_pc = redirect_pc & ~32'd3;
`endif
                end else if (instr_valid && instr_ready) begin
                    exp_pc = exp_pc + 32'd4;
                end
                held_prev = instr_valid && !instr_ready && !redirect_valid;
            end
            if (timeouts != to_seen) begin
                chk("wait_timeout", 32'(timeouts), 32'(to_seen));
                to_seen = timeouts;
            end
            if (done && !fin_done) begin
                chk("lit_queue_drained", 32'(lit_rd), 32'(lit_wr));
                fin_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic push_lit(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
        lit_kind[lit_wr[7:0]] = k;
        lit_v1[lit_wr[7:0]] = a;
        lit_v2[lit_wr[7:0]] = b;
        lit_wr++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        step(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200; i++) begin
            if (instr_valid) return;
            step(1);
        end
        timeouts++;
    endtask

    task automatic wait_mem_wait();
        for (int i = 0; i < 200; i++) begin
            if (mem_pending && !imem_resp_valid && !imem_req_valid) return;
            step(1);
        end
        timeouts++;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 200; i++) begin
            if (imem_resp_valid) return;
            step(1);
        end
        timeouts++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        push_lit(2'd0, 32'h0, 32'h0);
        push_lit(2'd1, 32'h0, 32'h4);
        push_lit(2'd1, 32'h4, 32'h8);
        push_lit(2'd1, 32'h8, 32'hC);
        step(3);
        rst = 1'b0;

        // zero-wait memory, decode always ready
        step(12);
        thru_win = 1'b1;
        step(30);
        thru_win = 1'b0;

        // decode stall
        wait_valid();
        dec_mode = 2;
        step(5);
        dec_mode = 1;
        step(6);

        // redirect while waiting on memory
        mem_lat_min = 3;
        mem_lat_max = 3;
        wait_mem_wait();
        redirect_to(32'h100);
        push_lit(2'd0, 32'h100, 32'h0);
        push_lit(2'd1, 32'h100, 32'h104);
        step(12);

        // redirect coinciding with a response
        mem_lat_min = 1;
        mem_lat_max = 1;
        wait_resp();
        redirect_to(32'h200);
        push_lit(2'd0, 32'h200, 32'h0);
        push_lit(2'd1, 32'h200, 32'h204);

        // redirect coinciding with decode consuming
        wait_valid();
        redirect_to(32'h200);
        push_lit(2'd0, 32'h200, 32'h0);
        push_lit(2'd1, 32'h200, 32'h204);
        step(9);

        // PC wrap
        redirect_to(32'hFFFF_FFFC);
        push_lit(2'd1, 32'hFFFF_FFFC, 32'h0);
        push_lit(2'd0, 32'h0, 32'h0);
        push_lit(2'd1, 32'h0, 32'h4);
        step(12);

        // misaligned redirect
`ifdef IFETCH_ALIGN_CHECK_EN
        redirect_to(32'h102);
        push_lit(2'd2, 32'h1, 32'h0);
        step(8);
        redirect_to(32'h104);
        push_lit(2'd0, 32'h104, 32'h0);
        push_lit(2'd1, 32'h104, 32'h108);
`else
        redirect_to(32'h102);
        push_lit(2'd0, 32'h100, 32'h0);
        push_lit(2'd1, 32'h100, 32'h104);
`endif
        step(12);

        // randomized traffic with redirects, spurious responses and mid-run resets
        mem_ready_pct = 60;
        mem_lat_max = 4;
        spurious_en = 1'b1;
        dec_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) begin
                redirect_valid = 1'b0;
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                      : $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
            redirect_pc[1:0] = 2'b00;
`endif
            step(1);
        end
        redirect_valid = 1'b0;
        step(20);

        done = 1'b1;
        for (int i = 0; i < 10 && !fin_done; i++) step(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage for the RV32I core. Sits directly upstream of the decoder and immediate generator, and feeds them a registered 32-bit instruction plus its PC.
- Owns the architectural fetch PC. Issues single-outstanding requests to instruction memory over a valid/ready handshake.
- Presents fetched instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any stale in-flight response.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid, one cycle pulse.
- imem_resp_data  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr_ready  in  1  decode consumes instr this cycle.
- instr  out  32  instruction to decoder/immgen.
- instr_pc  out  32  PC of instr.
- instr_pc_plus4  out  32  instr_pc+4, mod 2^32.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  new fetch target.
- align_fault  out  1  misaligned redirect flag; only present when the macro is defined.

Behaviour:
- Reset (async assert):
  - state=IDLE, fetch_pc=RESET_VECTOR, imem_req_valid=0, instr_valid=0.
  - instr=NOP_INSTR, instr_pc=0, instr_pc_plus4=4, drop flag=0.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: goes to REQ on the first clock after rst deasserts.
- REQ:
  - imem_req_valid=1 and imem_addr=fetch_pc, held stable until imem_req_ready.
  - On handshake, go to WAIT.
- WAIT:
  - imem_req_valid=0. Exactly one request is ever outstanding.
  - On imem_resp_valid with drop=0: instr<=imem_resp_data, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+4, go to HOLD.
  - A response may arrive in the cycle after acceptance at the earliest.
- HOLD:
  - instr_valid=1.
  - When instr_ready=1: instr_valid<=0, instr<=NOP_INSTR, go to REQ.
  - Best case is one instruction per 3 cycles with zero-wait memory.
- Redirect has the highest priority and is evaluated every cycle:
  - IDLE, REQ without handshake, or HOLD: fetch_pc<=redirect_pc with bits [1:0] forced to 0, instr_valid<=0, go to REQ. A held instruction is discarded even if instr_ready=1 in the same cycle.
  - REQ with handshake in the same cycle: the request is stale. fetch_pc<=redirect target, drop<=1, go to WAIT.
  - WAIT: fetch_pc<=redirect target, drop<=1.
  - WAIT with imem_resp_valid in the same cycle: the response is discarded, drop stays 0, go to REQ.
  - WAIT with drop=1 when a response arrives: discard it, clear drop, go to REQ.
- PC arithmetic: unsigned 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- rst asserted mid-transaction:
  - Everything returns to its reset values immediately.
  - Memory must also be reset. Any response arriving while in IDLE is ignored.
- imem_resp_valid outside WAIT is ignored.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets align_fault=1 (sticky), goes to IDLE-like halt state FAULT, and issues no requests.
  - Only rst or an aligned redirect clears align_fault. An aligned redirect also resumes fetch via REQ.
- Undefined:
  - No align_fault port and no FAULT state.
  - Low two bits of redirect_pc are silently masked.

Decomposition:
- Shared package rv32i_pkg holds:
  - ifetch state enum.
  - RV32I_NOP constant (32'h0000_0013).
  - XLEN=32 and the ILEN constant.
- One sub-module: ifetch_pc_reg. It is the fetch PC register with the redirect/increment mux and alignment masking.
- The FSM and the instruction holding register stay in ifetch_unit.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1:
  - First imem_addr=0x0.
  - instr=mem[0] with instr_pc=0, then instr_pc=4, 8.
  - instr_valid high 1 of every 3 cycles.
- Decode stalls (instr_ready=0 for 5 cycles):
  - instr and instr_pc are held stable.
  - No new imem request is issued.
  - Fetch resumes at pc+4 after ready.
- Redirect to 0x100 while in WAIT:
  - The response for the old address is discarded with instr_valid=0.
  - The next request uses addr 0x100.
  - The delivered instr_pc is 0x100.
- Redirect to 0x200 coinciding with imem_resp_valid in WAIT, and separately with instr_ready in HOLD:
  - In both cases the old instruction is never seen by decode.
  - The next addr is 0x200.
- Redirect to 0xFFFF_FFFC:
  - Delivered instr_pc=0xFFFF_FFFC and instr_pc_plus4=0.
  - The next fetch addr is 0x0.
- With IFETCH_ALIGN_CHECK_EN, redirect to 0x102:
  - align_fault=1 and imem_req_valid stays 0.
  - A later redirect to 0x104 clears the fault and fetches 0x104.
- Without the macro, redirect to 0x102: fetch addr is 0x100.
